fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch and next-PC stage sitting directly upstream of the control decoder in the single-cycle CPU. Holds the PC, fetches each instruction over a req/ack handshake and latches it into an instruction register. It presents opcode/funct to the decoder, then takes the decoder's Branch/BNE/Jump/Jal/Jr outputs plus the ALU zero flag and commits the next PC. Supports stall, halt and a fetch-timeout error.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT, 16, max cycles in FETCH without imem_ack before error (>=2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
imem_req  out  1  fetch request, high only in FETCH
imem_addr  out  32  fetch address (= pc)
imem_ack  in  1  instruction memory data valid this cycle
imem_rdata  in  32  instruction word, sampled when imem_req & imem_ack
instr  out  32  instruction register
instr_valid  out  1  high in EXEC; instr and control inputs are meaningful
opcode  out  6  instr[31:26], to decoder
funct  out  6  instr[5:0], to decoder
branch, bne, jump, jal, jr  in  1 each  decoder outputs for the current instr
alu_zero  in  1  ALU zero flag for the current instr
rs_data  in  32  register-file rs read data (jr/jalr target)
stall  in  1  hold EXEC; no PC commit
halt  in  1  sampled at commit; enter HALT after this instr
pc  out  32  current PC
pc_plus4  out  32  pc + 4, also the jal link value
fetch_err  out  1  sticky fetch-timeout flag

Behaviour:
- Reset (rst high at an edge): pc=RESET_PC, instr=0 (nop), state=FETCH, timeout counter=0, fetch_err=0. imem_req forced 0 and instr_valid 0 while rst is high. rst mid-fetch abandons the pending request; a late ack is ignored.
- States: FETCH, EXEC, HALT, ERR.
- FETCH: imem_req=1, imem_addr=pc. If imem_ack: instr<=imem_rdata, counter<=0, go to EXEC. Data is on instr the next cycle, so fetch latency is ack cycle +1. Otherwise counter increments. After TIMEOUT consecutive cycles without ack, go to ERR.
- EXEC: instr_valid=1. If stall, stay and hold pc and instr. If !stall: pc<=next_pc. Go to HALT if halt, else FETCH. Minimum 2 cycles per instruction with a zero-wait memory.
- next_pc priority:
  - jr: {rs_data[31:2],2'b00}; low bits are forced to zero.
  - jump (covers jal): {pc_plus4[31:28], instr[25:0], 2'b00}.
  - branch & (alu_zero ^ bne): pc_plus4 + (sign-extend(instr[15:0]) << 2). 32-bit wrap-around, no overflow detection.
  - otherwise pc_plus4.
  - jr and jump both high: jr wins.
- jal does not change target selection; the link value is pc_plus4, which the writeback path consumes.
- pc_plus4 wraps: 32'hFFFF_FFFC -> 32'h0000_0000.
- imem_ack outside FETCH is ignored.
- halt and stall are only sampled in EXEC. With stall and halt both high, the stall holds; halt is taken at the eventual commit.
- HALT: imem_req=0, instr_valid=0, pc holds the committed next_pc. Exit only by rst.
- ERR: fetch_err=1, imem_req=0, instr_valid=0, pc frozen at the failing address. Exit only by rst.
- All state updates are on the rising edge of clk. opcode, funct, pc_plus4, imem_addr and imem_req are combinational from registers.

Decomposition:
- Shared package: state encoding (FETCH/EXEC/HALT/ERR), OPC_J=6'h2, OPC_JAL=6'h3, OPC_BEQ=6'h4, OPC_BNE=6'h5, NOP=32'h0.
- One sub-module: next_pc_calc, purely combinational. Inputs pc, instr, rs_data, jump, jr, branch, bne, alu_zero; outputs pc_plus4 and next_pc. It is reusable by a later pipelined version.

Test Plan:
- Reset then sequential fetch, zero-wait ack, no control inputs -> pc goes 0x0, 0x4, 0x8; imem_addr matches; instr_valid high every 2nd cycle.
- beq at pc=0x10, imm=0xFFFE, alu_zero=1 -> next pc=0x0C. With alu_zero=0 -> 0x14. bne with alu_zero=0 -> 0x0C.
- j at pc=0x4000_0000, instr[25:0]=0x0000100 -> next pc=0x4000_0400. jr with rs_data=0x1237 and jump=1 -> 0x1234 (jr priority, low bits cleared).
- Ack delayed 3 cycles with stall held 2 cycles in EXEC -> instr captured once, pc unchanged until stall drops, then advances by 4.
- No ack for TIMEOUT=16 cycles -> ERR, fetch_err=1, imem_req=0, pc frozen. rst -> pc=RESET_PC, fetch_err=0.
- halt=1 at commit of pc=0x8 -> pc=0xC, state HALT, no further imem_req. rst asserted during a pending FETCH with ack in the same cycle -> instr stays 0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: FSM states, decoder opcodes and
// the branch-offset helper used by the next-PC logic.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2,
        ST_ERR   = 2'd3
    } state_e;

    localparam logic [5:0]  OPC_J   = 6'h2;
    localparam logic [5:0]  OPC_JAL = 6'h3;
    localparam logic [5:0]  OPC_BEQ = 6'h4;
    localparam logic [5:0]  OPC_BNE = 6'h5;
    localparam logic [31:0] NOP     = 32'h0000_0000;

    // Word-aligned byte offset of a 16-bit branch immediate.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage
// (master) and the instruction memory (slave).
interface fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_unit_next_pc.sv
// Combinational next-PC selection: jr > jump > taken branch > sequential.
module next_pc_calc
    import fetch_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic        jump,
    input  logic        jr,
    input  logic        branch,
    input  logic        bne,
    input  logic        alu_zero,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc
);

    logic take_branch;
    logic unused_bits;

    // Opcode field and low rs bits never reach a target address.
    assign unused_bits = &{1'b0, instr[31:26], rs_data[1:0]};

    // Priority select of the next PC; all sums wrap at 32 bits.
    always_comb begin
        pc_plus4    = pc + 32'd4;
        take_branch = branch & (alu_zero ^ bne);
        if (jr) begin
            next_pc = {rs_data[31:2], 2'b00};
        end else if (jump) begin
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (take_branch) begin
            next_pc = pc_plus4 + branch_offset(instr[15:0]);
        end else begin
            next_pc = pc_plus4;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch / next-PC stage: fetches over a req/ack bus, holds the
// instruction for the decoder, commits the next PC; supports stall, halt
// and a sticky fetch-timeout error.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic                clk,
    input  logic                rst,
    fetch_unit_if.master        imem,
    output logic [31:0]         instr,
    output logic                instr_valid,
    output logic [5:0]          opcode,
    output logic [5:0]          funct,
    input  logic                branch,
    input  logic                bne,
    input  logic                jump,
    input  logic                jal,
    input  logic                jr,
    input  logic                alu_zero,
    input  logic [31:0]         rs_data,
    input  logic                stall,
    input  logic                halt,
    output logic [31:0]         pc,
    output logic [31:0]         pc_plus4,
    output logic                fetch_err
);

    localparam int unsigned       CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  MISS_LAST = CNT_W'(TIMEOUT - 1);

    state_e             state_q;
    logic [31:0]        pc_q;
    logic [31:0]        instr_q;
    logic [CNT_W-1:0]   miss_q;
    logic               err_q;
    logic [31:0]        next_pc_d;
    logic               unused_jal;

    // jal only affects writeback (link = pc_plus4), not target selection.
    assign unused_jal = jal;

    next_pc_calc u_next_pc (
        .pc       (pc_q),
        .instr    (instr_q),
        .rs_data  (rs_data),
        .jump     (jump),
        .jr       (jr),
        .branch   (branch),
        .bne      (bne),
        .alu_zero (alu_zero),
        .pc_plus4 (pc_plus4),
        .next_pc  (next_pc_d)
    );

    // Fetch/exec sequencer with timeout counting; reset overrides any ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= NOP;
            miss_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (imem.imem_ack) begin
                        instr_q <= imem.imem_rdata;
                        miss_q  <= '0;
                        state_q <= ST_EXEC;
                    end else if (miss_q == MISS_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= ST_ERR;
                    end else begin
                        miss_q  <= miss_q + CNT_W'(1);
                    end
                end
                ST_EXEC: begin
                    if (!stall) begin
                        pc_q    <= next_pc_d;
                        state_q <= halt ? ST_HALT : ST_FETCH;
                    end
                end
                default: begin
                    // HALT and ERR are left only through reset.
                end
            endcase
        end
    end

    assign imem.imem_req  = (state_q == ST_FETCH) && !rst;
    assign imem.imem_addr = pc_q;
    assign instr_valid    = (state_q == ST_EXEC) && !rst;
    assign instr          = instr_q;
    assign opcode         = instr_q[31:26];
    assign funct          = instr_q[5:0];
    assign pc             = pc_q;
    assign fetch_err      = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: behavioural model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr, pc, pc_plus4, rs_data;
    logic [5:0]  opcode, funct;
    logic        instr_valid, fetch_err;
    logic        branch, bne, jump, jal, jr, alu_zero, stall, halt;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem        (bus.master),
        .instr       (instr),
        .instr_valid (instr_valid),
        .opcode      (opcode),
        .funct       (funct),
        .branch      (branch),
        .bne         (bne),
        .jump        (jump),
        .jal         (jal),
        .jr          (jr),
        .alu_zero    (alu_zero),
        .rs_data     (rs_data),
        .stall       (stall),
        .halt        (halt),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- instruction memory ----------------
    logic [31:0] mem [logic [31:0]];
    int          mem_lat  = 0;
    bit          mem_dead = 1'b0;
    bit          force_ack = 1'b0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    int          req_cyc = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h1357_9BDF;
    endfunction

    always @(posedge clk) begin
        #2;
        mem_rdata = mem_word(bus.imem_addr);
        if (bus.imem_req && !mem_dead) begin
            if (req_cyc >= mem_lat) begin
                mem_ack = 1'b1;
                req_cyc = 0;
            end else begin
                mem_ack = 1'b0;
                req_cyc++;
            end
        end else begin
            mem_ack = 1'b0;
            req_cyc = 0;
        end
    end

    assign bus.imem_ack   = mem_ack | force_ack;
    assign bus.imem_rdata = force_ack ? 32'hDEAD_BEEF : mem_rdata;

    // ---------------- behavioural model ----------------
    localparam int M_FETCH = 0, M_EXEC = 1, M_HALT = 2, M_ERR = 3;
    int          m_mode;
    int          m_miss;
    logic [31:0] m_pc, m_instr;
    bit          m_err;

    function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] ins,
                                             input logic [31:0] rs, input logic jr_,
                                             input logic jp_, input logic br_,
                                             input logic bn_, input logic z_);
        logic [31:0]        seq;
        logic signed [15:0] imm;
        int                 off;
        seq = p + 32'd4;
        if (jr_) return rs & 32'hFFFF_FFFC;
        if (jp_) return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
        if (br_ && (z_ != bn_)) begin
            imm = ins[15:0];
            off = int'(imm) * 4;
            return seq + 32'(off);
        end
        return seq;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_mode  = M_FETCH;
            m_miss  = 0;
            m_pc    = 32'h0;
            m_instr = 32'h0;
            m_err   = 1'b0;
        end else if (m_mode == M_FETCH) begin
            if (bus.imem_ack) begin
                m_instr = mem_word(m_pc);
                m_miss  = 0;
                m_mode  = M_EXEC;
            end else begin
                m_miss++;
                if (m_miss == TO) begin
                    m_mode = M_ERR;
                    m_err  = 1'b1;
                end
            end
        end else if (m_mode == M_EXEC && !stall) begin
            m_pc   = ref_next(m_pc, m_instr, rs_data, jr, jump, branch, bne, alu_zero);
            m_mode = halt ? M_HALT : M_FETCH;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc", pc, m_pc);
            chk("imem_addr", bus.imem_addr, m_pc);
            chk("pc_plus4", pc_plus4, m_pc + 32'd4);
            chk("instr", instr, m_instr);
            chk("opcode", 32'(opcode), m_instr >> 26);
            chk("funct", 32'(funct), m_instr & 32'h3F);
            chk("instr_valid", 32'(instr_valid), 32'(m_mode == M_EXEC && !rst));
            chk("imem_req", 32'(bus.imem_req), 32'(m_mode == M_FETCH && !rst));
            chk("fetch_err", 32'(fetch_err), 32'(m_err));
        end
    end

    // ---------------- stimulus ----------------
    task automatic clear_ctrl();
        branch = 0; bne = 0; jump = 0; jal = 0; jr = 0; alu_zero = 0;
        rs_data = '0; stall = 0; halt = 0; force_ack = 0;
    endtask

    task automatic exec_instr(input logic i_br, input logic i_bne, input logic i_jp,
                              input logic i_jal, input logic i_jr, input logic i_z,
                              input logic [31:0] i_rs, input logic i_halt,
                              input int n_stall, input logic ack_in_stall);
        bit found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            @(negedge clk);
            if (instr_valid) found = 1'b1;
        end
        chk("exec_wait", 32'(found), 32'd1);
        if (!found) return;
        branch = i_br; bne = i_bne; jump = i_jp; jal = i_jal; jr = i_jr;
        alu_zero = i_z; rs_data = i_rs; halt = i_halt;
        stall = (n_stall > 0);
        force_ack = ack_in_stall && (n_stall > 0);
        for (int s = 0; s < n_stall; s++) @(negedge clk);
        stall = 0;
        force_ack = 0;
        @(posedge clk);
        #1;
        clear_ctrl();
    endtask

    task automatic plain();
        exec_instr(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
    endtask

    initial begin
        int  cnt;
        bit  got;
        rst = 1;
        clear_ctrl();
        mem[32'h0000_0000] = 32'h2001_0005;
        mem[32'h0000_0010] = {OPC_BEQ, 5'd1, 5'd2, 16'hFFFE};
        mem[32'h4000_0000] = {OPC_J, 26'h000_0100};
        mem[32'h4000_0400] = {6'h00, 5'd31, 15'h0, 6'h08};
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        rst = 0;

        // Sequential fetch, zero-wait memory, no control inputs.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("seq_valid", 32'(instr_valid), 32'(i % 2));
            chk("seq_pc", pc, 32'((i / 2) * 4));
            if (i == 0) begin
                chk("rst_instr", instr, 32'h0);
                chk("rst_err", 32'(fetch_err), 32'd0);
            end
        end
        @(posedge clk); #1;
        chk("seq_pc_c", pc, 32'h0000_000C);

        // Branches at 0x10 with imm = -2 words.
        plain();
        chk("pc_10", pc, 32'h0000_0010);
        exec_instr(1, 0, 0, 0, 0, 1, 32'h0, 0, 0, 0);
        chk("beq_taken", pc, 32'h0000_000C);
        plain();
        exec_instr(1, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0);
        chk("beq_not_taken", pc, 32'h0000_0014);
        exec_instr(0, 0, 0, 0, 1, 0, 32'h0000_0010, 0, 0, 0);
        exec_instr(1, 1, 0, 0, 0, 0, 32'h0, 0, 0, 0);
        chk("bne_taken", pc, 32'h0000_000C);

        // Jump region and jr priority.
        exec_instr(0, 0, 0, 0, 1, 0, 32'h4000_0000, 0, 0, 0);
        chk("jr_4000", pc, 32'h4000_0000);
        exec_instr(0, 0, 1, 0, 0, 0, 32'h0, 0, 0, 0);
        chk("j_target", pc, 32'h4000_0400);
        exec_instr(0, 0, 1, 1, 1, 0, 32'h0000_1237, 0, 0, 0);
        chk("jr_priority", pc, 32'h0000_1234);

        // pc_plus4 wrap-around.
        exec_instr(0, 0, 0, 0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0);
        chk("pc_top", pc, 32'hFFFF_FFFC);
        chk("pc_plus4_wrap", pc_plus4, 32'h0000_0000);
        plain();
        chk("pc_wrapped", pc, 32'h0000_0000);

        // Delayed ack, stall in EXEC with a stray ack that must be ignored.
        mem_lat = 3;
        exec_instr(0, 0, 0, 0, 0, 0, 32'h0, 0, 2, 1);
        chk("stall_instr", instr, 32'h2001_0005);
        chk("stall_pc", pc, 32'h0000_0004);

        // Fetch timeout.
        mem_dead = 1;
        cnt = 0;
        got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (fetch_err) got = 1;
            else if (bus.imem_req) cnt++;
        end
        chk("timeout_seen", 32'(got), 32'd1);
        chk("timeout_cycles", 32'(cnt), 32'(TO));
        repeat (3) @(negedge clk);
        chk("err_req", 32'(bus.imem_req), 32'd0);
        chk("err_pc", pc, 32'h0000_0004);
        mem_dead = 0;
        mem_lat = 0;
        rst = 1;
        @(posedge clk); #1;
        chk("rst_pc", pc, 32'h0000_0000);
        chk("rst_clears_err", 32'(fetch_err), 32'd0);
        rst = 0;

        // Halt at commit of 0x8, with stall held alongside halt.
        plain();
        plain();
        chk("pc_8", pc, 32'h0000_0008);
        exec_instr(0, 0, 0, 0, 0, 0, 32'h0, 1, 1, 0);
        chk("halt_pc", pc, 32'h0000_000C);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("halt_no_req", 32'(bus.imem_req), 32'd0);
            chk("halt_no_valid", 32'(instr_valid), 32'd0);
        end

        // Reset during a pending fetch with an ack in the same cycle.
        mem_dead = 1;
        do_reset();
        @(posedge clk); #1;
        rst = 1;
        force_ack = 1;
        @(posedge clk); #1;
        chk("rst_ack_instr", instr, 32'h0);
        @(posedge clk); #1;
        rst = 0;
        force_ack = 0;
        @(negedge clk);
        chk("rst_ack_instr2", instr, 32'h0);
        mem_dead = 0;
        repeat (4) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

endmodule
